bus_uart_device: RTL



---
 rtl/bus_uart_device.sv | 335 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_uart_device.sv
// Memory-mapped 8N1 UART: TX/RX byte FIFOs, four-register CSR window, RX interrupt source.
// Reads return data one cycle after the strobe; no wait states; full FIFOs drop and flag.

module bus_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dat     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

module bus_uart_device #(
  parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_1000_0000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic [3:0]  interrupt_vector,
  input  logic        interrupt_ack,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int           CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;
  typedef enum logic [1:0] {I_IDLE, I_RAISED, I_SERVICED} irq_st_t;

  // Bus decode
  logic       w_hit;
  logic [1:0] w_idx;
  logic       w_wr;
  logic       w_rd;
  logic       w_unused;

  assign w_hit    = (bus_address[63:5] == BASE_ADDR[63:5]);
  assign w_idx    = bus_address[4:3];
  assign w_wr     = bus_write_enable && w_hit;
  assign w_rd     = bus_read_enable && !bus_write_enable && w_hit;
  assign w_unused = ^{bus_write_data[63:8], bus_address[2:0]};

  // FIFOs
  logic       w_tx_push_req;
  logic       w_tx_pop;
  logic [7:0] w_tx_dout;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_rx_push;
  logic       w_rx_pop;
  logic [7:0] w_rx_dout;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic [7:0] r_rx_shift;

  assign w_tx_push_req = w_wr && (w_idx == 2'd0);
  assign w_rx_pop      = w_rd && (w_idx == 2'd1) && !w_rx_empty;

  bus_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_tx_push_req),
    .i_pop   (w_tx_pop),
    .i_dat   (bus_write_data[7:0]),
    .o_dat   (w_tx_dout),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  bus_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_dat   (r_rx_shift),
    .o_dat   (w_rx_dout),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // TX serializer
  uart_st_t      r_tx_st, w_tx_st_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_bit, w_tx_bit_nxt;
  logic [7:0]    r_tx_shift, w_tx_shift_nxt;
  logic          r_uart_tx, w_tx_line_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_st    <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      r_tx_st    <= w_tx_st_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_uart_tx  <= w_tx_line_nxt;
    end
  end

  always_comb begin
    w_tx_st_nxt    = r_tx_st;
    w_tx_cnt_nxt   = r_tx_cnt + CW'(1);
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_pop       = 1'b0;
    case (r_tx_st)
      S_IDLE: begin
        w_tx_cnt_nxt = '0;
        if (!w_tx_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_st_nxt    = S_START;
          w_tx_shift_nxt = w_tx_dout;
        end
      end
      S_START: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt = '0;
          w_tx_bit_nxt = '0;
          w_tx_st_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          if (r_tx_bit == 3'd7) w_tx_st_nxt = S_STOP;
          else                  w_tx_bit_nxt = r_tx_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt = '0;
          // Chain straight into the next start bit so frames are gapless.
          if (!w_tx_empty) begin
            w_tx_pop       = 1'b1;
            w_tx_st_nxt    = S_START;
            w_tx_shift_nxt = w_tx_dout;
          end else begin
            w_tx_st_nxt = S_IDLE;
          end
        end
      end
      default: w_tx_st_nxt = S_IDLE;
    endcase
    case (w_tx_st_nxt)
      S_START: w_tx_line_nxt = 1'b0;
      S_DATA:  w_tx_line_nxt = w_tx_shift_nxt[0];
      default: w_tx_line_nxt = 1'b1;
    endcase
  end

  assign uart_tx = r_uart_tx;

  // RX deserializer
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  uart_st_t      r_rx_st, w_rx_st_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_rx_bit, w_rx_bit_nxt;
  logic [7:0]    w_rx_shift_nxt;
  logic          w_ferr_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_st    <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1    <= uart_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_st    <= w_rx_st_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  always_comb begin
    w_rx_st_nxt    = r_rx_st;
    w_rx_cnt_nxt   = r_rx_cnt + CW'(1);
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_push      = 1'b0;
    w_ferr_set     = 1'b0;
    case (r_rx_st)
      S_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_prev && !r_rx_s2) w_rx_st_nxt = S_START;
      end
      S_START: begin
        // Mid-start check rejects glitches shorter than half a bit.
        if (r_rx_cnt == CNT_HALF) begin
          w_rx_cnt_nxt = '0;
          w_rx_bit_nxt = '0;
          w_rx_st_nxt  = r_rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_st_nxt = S_STOP;
          else                  w_rx_bit_nxt = r_rx_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_nxt = '0;
          w_rx_st_nxt  = S_IDLE;
          w_rx_push    = r_rx_s2;
          w_ferr_set   = !r_rx_s2;
        end
      end
      default: w_rx_st_nxt = S_IDLE;
    endcase
  end

  // Sticky status flags and control
  logic r_tx_ovf, r_rx_ovr, r_ferr, r_ctrl;
  logic w_stat_rd;

  assign w_stat_rd = w_rd && (w_idx == 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovr <= 1'b0;
      r_ferr   <= 1'b0;
      r_ctrl   <= 1'b0;
    end else begin
      r_tx_ovf <= (w_tx_push_req && w_tx_full) || (r_tx_ovf && !w_stat_rd);
      r_rx_ovr <= (w_rx_push && w_rx_full) || (r_rx_ovr && !w_stat_rd);
      r_ferr   <= w_ferr_set || (r_ferr && !w_stat_rd);
      if (w_wr && (w_idx == 2'd3)) r_ctrl <= bus_write_data[0];
    end
  end

  // Read data
  logic [63:0] w_rdata;
  logic [63:0] r_rdata;

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      2'd1:    w_rdata = {55'b0, !w_rx_empty, (w_rx_empty ? 8'h00 : w_rx_dout)};
      2'd2:    w_rdata = {58'b0, r_ferr, r_rx_ovr, r_tx_ovf, w_rx_empty, w_tx_full, w_tx_empty};
      2'd3:    w_rdata = {63'b0, r_ctrl};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_rdata <= '0;
    else if (bus_read_enable) r_rdata <= w_rd ? w_rdata : 64'd0;
  end

  assign bus_read_data = r_rdata;

  // Interrupt handshake
  irq_st_t    r_irq_st, w_irq_st_nxt;
  logic [3:0] r_irq_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_st  <= I_IDLE;
      r_irq_vec <= 4'd0;
    end else begin
      r_irq_st  <= w_irq_st_nxt;
      r_irq_vec <= (w_irq_st_nxt == I_RAISED) ? 4'd1 : 4'd0;
    end
  end

  always_comb begin
    w_irq_st_nxt = r_irq_st;
    case (r_irq_st)
      I_IDLE:     if (r_ctrl && !w_rx_empty) w_irq_st_nxt = I_RAISED;
      I_RAISED: begin
        if (!r_ctrl)            w_irq_st_nxt = I_IDLE;
        else if (interrupt_ack) w_irq_st_nxt = I_SERVICED;
      end
      I_SERVICED: if (w_rx_empty || !r_ctrl) w_irq_st_nxt = I_IDLE;
      default:    w_irq_st_nxt = I_IDLE;
    endcase
  end

  assign interrupt_vector = r_irq_vec;
endmodule
